// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Takes ownership of the open-collector
// clock/data pair for one frame: holds the clock low (inhibit), requests to
// send by pulling data low, then shifts 8 data bits (LSB first), odd parity
// and the stop bit on device-generated clock falls, and finally samples the
// device ACK bit. Both lines are handed back once the device returns them to
// idle (or immediately on timeout).
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   tx_data     byte to send, bit 0 = MSB
//   tx_start    one-cycle send request, accepted only while tx_busy = 0
//   tx_busy     high from the cycle after acceptance until tx_done
//   tx_done     one-cycle pulse at end of frame (success or failure)
//   tx_error    with tx_done: 1 = NACK or timeout; held until next acceptance
//   ps2_clk_in  raw PS/2 clock line (asynchronous)
//   ps2_dat_in  raw PS/2 data line (asynchronous)
//   ps2_clk_oe  1 = drive PS/2 clock low, 0 = release
//   ps2_dat_oe  1 = drive PS/2 data low, 0 = release
// ----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [0:7] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    // The inhibit counter stops one short of INHIBIT_CYCLES because the
    // request-to-send cycle that follows still holds the clock low; together
    // they give exactly INHIBIT_CYCLES cycles of clock inhibit.
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronisers and a clock glitch filter.
    // Synchronisers reset to 1, the idle level of a pulled-up PS/2 line.
    // ------------------------------------------------------------------
    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_filt;
    logic             clk_fall;
    logic [FLT_W-1:0] flt_cnt;
    logic             dat_s;

    assign dat_s = dat_sync[1];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            clk_fall <= 1'b0;
            flt_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                // FILTER_LEN consecutive samples disagreed: accept new level.
                clk_filt <= clk_sync[1];
                clk_fall <= clk_filt;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t           state;
    logic [0:7]       data_q;
    logic             parity_q;
    logic [3:0]       bit_idx;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_idx    <= '0;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        data_q     <= tx_data;
                        parity_q   <= ~^tx_data;
                        tx_error   <= 1'b0;
                        tx_busy    <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        inh_cnt    <= '0;
                        state      <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;     // start bit
                        state      <= S_RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                S_RTS: begin
                    ps2_clk_oe <= 1'b0;         // hand the clock to the device
                    bit_idx    <= '0;
                    tmo_cnt    <= '0;
                    state      <= S_SHIFT;
                end

                S_SHIFT, S_ACK: begin
                    if (tmo_cnt == TMO_LAST) begin
                        // Timeout wins over a fall in the same cycle.
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        tx_done    <= 1'b1;
                        tx_busy    <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (clk_fall) begin
                            if (state == S_ACK) begin
                                tx_error <= dat_s;  // device holds data low to ACK
                                state    <= S_WAIT_IDLE;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                                if (bit_idx < 4'd8) begin
                                    // bit 7 of the ascending byte is the LSB
                                    ps2_dat_oe <= ~data_q[3'd7 - bit_idx[2:0]];
                                end else if (bit_idx == 4'd8) begin
                                    ps2_dat_oe <= ~parity_q;
                                end else begin
                                    ps2_dat_oe <= 1'b0;     // stop bit
                                    state      <= S_ACK;
                                end
                            end
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_filt && dat_s) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Drives ps2_host_tx against a behavioural PS/2 keyboard model. Timing is
// scaled down so a full run stays short: inhibit 250 cycles, timeout 3000
// cycles, device clock period 80 system cycles.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH = 250;
    localparam int TMO = 3000;
    localparam int FLT = 8;
    localparam int H   = 40;    // device clock half period in system cycles

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    logic dev_clk_low;
    logic dev_dat_low;

    // Open-collector bus with pull-ups: low if anyone drives it.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    int total = 0;
    int bad   = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Passive monitor: inhibit length, release time, tx_done events.
    // ------------------------------------------------------------------
    int   cyc = 0;
    int   req_cnt = 0;
    int   clk_oe_run = 0;
    int   inh_len = 0;
    int   release_cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic done_err = 1'b0;
    logic done_busy = 1'b0;
    logic done_prev_busy = 1'b0;
    logic prev_clk_oe = 1'b0;
    logic prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (ps2_clk_oe && !prev_clk_oe) req_cnt++;
            if (ps2_clk_oe) begin
                clk_oe_run++;
            end else begin
                if (prev_clk_oe) begin
                    inh_len     = clk_oe_run;
                    release_cyc = cyc;
                end
                clk_oe_run = 0;
            end
            if (tx_done) begin
                done_err       = tx_error;
                done_busy      = tx_busy;
                done_prev_busy = prev_busy;
                done_cyc       = cyc;
                done_cnt++;
            end
            prev_clk_oe = ps2_clk_oe;
            prev_busy   = tx_busy;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line levels the device should see: 8 data bits LSB first, odd parity,
    // stop bit (index 9).
    function automatic logic [9:0] expected_bits(input logic [7:0] b);
        logic [9:0] e;
        for (int i = 0; i < 8; i++) e[i] = b[i];
        e[8] = (($countones(b) % 2) == 0);  // total count of ones must be odd
        e[9] = 1'b1;
        return e;
    endfunction

    task automatic send_start(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Keyboard model: waits for request-to-send, clocks 10 bits sampling the
    // data line at each rising edge, then answers the 11th clock with ACK
    // (data low) or leaves data high. abort_after > 0 stops after that many
    // clocks with the lines released.
    task automatic device_frame(input bit do_ack, input bit glitch, input int abort_after,
                                output logic start_bit, output logic [9:0] bits, output bit ok);
        int n;
        bits      = '0;
        start_bit = 1'b1;
        ok        = 1'b0;
        n         = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < INH + 100) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) return;
        ok = 1'b1;
        repeat (20) @(negedge clk);
        start_bit = ps2_dat_in;
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            bits[i]     = ps2_dat_in;
            dev_clk_low = 1'b0;
            if (abort_after != 0 && i + 1 == abort_after) return;
            if (glitch && i == 3) begin
                repeat (10) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (H - 13) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        dev_dat_low = do_ack;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_dat_low = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit do_ack, input bit glitch,
                             input bit poke, input string tag);
        int         d0;
        int         r0;
        logic       sb;
        logic [9:0] bits;
        logic [9:0] exp;
        bit         ok;
        exp = expected_bits(b);
        d0  = done_cnt;
        send_start(b);
        check({tag, " busy_after_start"}, tx_busy, 1);
        check({tag, " error_cleared"}, tx_error, 0);
        if (poke) begin
            repeat (50) @(negedge clk);
            check({tag, " busy_mid_frame"}, tx_busy, 1);
            tx_data  = 8'h55;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
        end
        device_frame(do_ack, glitch, 0, sb, bits, ok);
        check({tag, " rts_seen"}, ok, 1);
        check({tag, " inhibit_len"}, inh_len, INH);
        check({tag, " start_bit"}, sb, 0);
        check({tag, " frame_bits"}, bits, exp);
        check({tag, " parity_bit"}, bits[8], exp[8]);
        wait_done(d0, 300, tag);
        check({tag, " error"}, done_err, !do_ack);
        check({tag, " busy_at_done"}, done_busy, 0);
        check({tag, " busy_before_done"}, done_prev_busy, 1);
        repeat (2) @(negedge clk);
        check({tag, " clk_oe_after"}, ps2_clk_oe, 0);
        check({tag, " dat_oe_after"}, ps2_dat_oe, 0);
        if (poke) begin
            r0 = req_cnt;
            repeat (INH + 50) @(negedge clk);
            check({tag, " no_extra_frame"}, req_cnt - r0, 0);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] rb;
        bit         ra;
        logic       sb;
        logic [9:0] bits;
        logic [9:0] e;
        bit         ok;
        int         d0;

        reset_n     = 1'b0;
        tx_start    = 1'b0;
        tx_data     = '0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", tx_busy, 0);
        check("reset done", tx_done, 0);
        check("reset error", tx_error, 0);
        check("reset clk_oe", ps2_clk_oe, 0);
        check("reset dat_oe", ps2_dat_oe, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // LED command, ACKed
        run_frame(8'hED, 1'b1, 1'b0, 1'b0, "ed");

        // parity corners
        run_frame(8'h00, 1'b1, 1'b0, 1'b0, "x00");
        run_frame(8'hFF, 1'b1, 1'b0, 1'b0, "xff");
        run_frame(8'h01, 1'b1, 1'b0, 1'b0, "x01");
        run_frame(8'h80, 1'b1, 1'b0, 1'b0, "x80");

        // random bytes with random ACK/NACK
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            run_frame(rb, ra, 1'b0, 1'b0, "rand");
        end

        // NACK: error held until next acceptance
        run_frame(8'h3C, 1'b0, 1'b0, 1'b0, "nack");
        repeat (20) @(negedge clk);
        check("nack error_hold", tx_error, 1);

        // clock glitch during SHIFT must not advance the bit index
        run_frame(8'h96, 1'b1, 1'b1, 1'b0, "glitch");

        // tx_start while busy must not disturb the frame
        run_frame(8'hED, 1'b1, 1'b0, 1'b1, "busy");

        // device never clocks
        d0 = done_cnt;
        send_start(8'h5A);
        wait_done(d0, INH + TMO + 200, "timeout");
        check("timeout latency", done_cyc - release_cyc, TMO);
        check("timeout error", done_err, 1);
        check("timeout busy_at_done", done_busy, 0);
        repeat (2) @(negedge clk);
        check("timeout clk_oe_after", ps2_clk_oe, 0);
        check("timeout dat_oe_after", ps2_dat_oe, 0);

        // reset after the 4th data bit
        d0 = done_cnt;
        e  = expected_bits(8'hA5);
        send_start(8'hA5);
        device_frame(1'b1, 1'b0, 4, sb, bits, ok);
        check("rst rts_seen", ok, 1);
        check("rst first_bits", bits[3:0], e[3:0]);
        check("rst dat_oe_before", ps2_dat_oe, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst clk_oe_async", ps2_clk_oe, 0);
        check("rst dat_oe_async", ps2_dat_oe, 0);
        check("rst busy_async", tx_busy, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("rst no_done", done_cnt - d0, 0);

        // fresh frame after the reset
        run_frame(8'hF4, 1'b1, 1'b0, 1'b0, "f4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
